// File: rtl/qlf_k4n8_cfg_loader.sv
// qlf_k4n8_cfg_loader: streams DATA_W-bit configuration words, LSB first,
// into a k4n8 tile's scff chain and pulses done after CHAIN_LEN bits.
// Optional readback of the chain's previous contents: QLF_K4N8_CFG_READBACK_EN.
module qlf_k4n8_cfg_loader #(
    parameter int unsigned DATA_W    = 8,
    parameter int unsigned CHAIN_LEN = 40
) (
    input  logic              clk,
    input  logic              R,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    output logic              scan_en,
    output logic              scan_d,
    input  logic              scan_q,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic [DATA_W-1:0] rd_word,
    output logic              rd_valid
);

    localparam int unsigned CNT_W  = $clog2(CHAIN_LEN + 1);
    localparam int unsigned LEFT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CHAIN_LEN);
    localparam logic [CNT_W-1:0]  CNT_FINAL = CNT_W'(CHAIN_LEN - 1);
    localparam logic [LEFT_W-1:0] LEFT_NEW  = LEFT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Buffer holds the bits still to shift after the one currently driven;
    // an accepted word bypasses the buffer so its bit 0 leaves immediately.
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [LEFT_W-1:0] left_q, left_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic              scan_en_d, scan_d_d, busy_d, done_d, aborted_d;
    logic              hs_c, shift_c;
    logic [DATA_W-1:0] src_c;

    // Ready when the buffer drains this cycle and the chain still wants bits
    assign cfg_ready = (state_q == LOAD) && !abort && (left_q == '0) &&
                       (bit_cnt_q < CNT_LAST);
    assign hs_c      = cfg_valid && cfg_ready;
    assign src_c     = hs_c ? cfg_data : buf_q;
    assign shift_c   = (state_q == LOAD) && !abort && (hs_c || (left_q != '0));

    // State register
    always_ff @(posedge clk) begin
        if (R) state_q <= IDLE;
        else   state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD: begin
                if (abort)                                  state_d = IDLE;
                else if (shift_c && (bit_cnt_q == CNT_FINAL)) state_d = FINISH;
            end
            FINISH:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output and datapath next values
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        left_d    = left_q;
        buf_d     = buf_q;
        scan_en_d = 1'b0;
        scan_d_d  = scan_d;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    bit_cnt_d = '0;
                    left_d    = '0;
                    buf_d     = '0;
                end
            end
            LOAD: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    left_d    = '0;
                    buf_d     = '0;
                end else if (shift_c) begin
                    scan_en_d = 1'b1;
                    scan_d_d  = src_c[0];
                    buf_d     = src_c >> 1;
                    left_d    = hs_c ? LEFT_NEW : left_q - LEFT_W'(1);
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    if (bit_cnt_q == CNT_FINAL) begin
                        // drop unused upper bits of the final word
                        left_d = '0;
                        buf_d  = '0;
                    end
                end
            end
            FINISH:  done_d = 1'b1;
            default: ;
        endcase
        busy_d = (state_d == LOAD);
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (R) begin
            bit_cnt_q <= '0;
            left_q    <= '0;
            buf_q     <= '0;
            scan_en   <= 1'b0;
            scan_d    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            aborted   <= 1'b0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            left_q    <= left_d;
            buf_q     <= buf_d;
            scan_en   <= scan_en_d;
            scan_d    <= scan_d_d;
            busy      <= busy_d;
            done      <= done_d;
            aborted   <= aborted_d;
        end
    end

`ifdef QLF_K4N8_CFG_READBACK_EN
    logic [DATA_W-1:0] rd_acc_q, rd_acc_c;
    logic [LEFT_W-1:0] rd_cnt_q;

    assign rd_acc_c = rd_acc_q | (DATA_W'(scan_q) << rd_cnt_q);

    // Pack chain tail bits LSB first; flush a partial word at FINISH
    always_ff @(posedge clk) begin
        if (R) begin
            rd_acc_q <= '0;
            rd_cnt_q <= '0;
            rd_word  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= 1'b0;
            if ((state_q == LOAD) && abort) begin
                rd_acc_q <= '0;
                rd_cnt_q <= '0;
            end else if (scan_en) begin
                if ((rd_cnt_q == LEFT_NEW) || (state_q == FINISH)) begin
                    rd_word  <= rd_acc_c;
                    rd_valid <= 1'b1;
                    rd_acc_q <= '0;
                    rd_cnt_q <= '0;
                end else begin
                    rd_acc_q <= rd_acc_c;
                    rd_cnt_q <= rd_cnt_q + LEFT_W'(1);
                end
            end
        end
    end
`else
    logic unused_scan_q;

    // No readback: chain tail is ignored
    assign unused_scan_q = scan_q;
    assign rd_word       = '0;
    assign rd_valid      = 1'b0;
`endif

endmodule
